maxpool_frame_ctrl: RTL and testbench
=====================================

// Module: maxpool_frame_ctrl
// PURPOSE
//  Sequences the binary max_pooling datapath over CHANNELS feature maps of WIDTH x HEIGHT bits.
//  - Reads each map from the conv output bit-RAM (1-cycle read latency) and streams it raster-order into the pooling block.
//  - Writes every pooled bit to the pool output bit-RAM at a packed address.
//  - Resets the pooling block between channels; reports done/error to the layer sequencer.
// PARAMETERS
//  WIDTH      26  input map width  (even, >=4)
//  HEIGHT     26  input map height (even, >=4)
//  CHANNELS   4   feature maps per start
//  RD_AW      12  read address width  (>= clog2(CHANNELS*WIDTH*HEIGHT))
//  WR_AW      10  write address width (>= clog2(CHANNELS*WIDTH*HEIGHT/4))
//  DRAIN_MAX  64  max cycles in DRAIN before timeout
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      async active-low reset
//  start       in   1      1-cycle pulse, accepted only in IDLE
//  busy        out  1      high from accept until done pulse (inclusive)
//  done        out  1      1-cycle pulse, all channels written
//  err         out  1      sticky drain timeout; cleared by next accepted start
//  rd_en       out  1      input RAM read strobe
//  rd_addr     out  RD_AW  input RAM address
//  rd_data     in   1      input bit, valid 1 cycle after rd_en
//  pool_rst_n  out  1      sync-deasserted reset to max_pooling
//  pool_pixel  out  1      pixel_in of max_pooling
//  pool_out    in   1      maxpool_out
//  pool_valid  in   1      valid_out_maxpool
//  wr_en       out  1      output RAM write strobe
//  wr_addr     out  WR_AW  output RAM address
//  wr_data     out  1      output bit
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err, rd_en, wr_en=0; rd_addr, wr_addr, wr_data, pool_pixel=0; pool_rst_n=0.
//  Constants: NPIX=WIDTH*HEIGHT, NPOOL=(WIDTH/2)*(HEIGHT/2); ch = channel index 0..CHANNELS-1.
//  FSM:
//   IDLE : pool_rst_n=0. start -> CLR with ch=0, err=0, busy=1. start in any other state is ignored.
//   CLR  : pool_rst_n=0 for exactly 2 cycles; out_cnt=0, pix_cnt=0 -> FEED.
//   FEED : pool_rst_n=1; rd_en=1 every cycle; rd_addr=ch*NPIX+pix_cnt.
//          pix_cnt==NPIX-1 issues the last read -> DRAIN.
//   DRAIN: rd_en=0; pool_pixel keeps being driven (last read data, then 0); wait out_cnt==NPOOL -> NEXT.
//          After DRAIN_MAX cycles without completion: err=1 -> NEXT (missing outputs are not written).
//   NEXT : ch==CHANNELS-1 -> DONE; else ch++ -> CLR.
//   DONE : done=1 for 1 cycle, busy=0 -> IDLE.
//  Data path:
//   pool_pixel <= rd_data registered in the cycle after rd_en.
//   Pixel k of a channel reaches pixel_in exactly 2 cycles after its read is issued; no gaps within a channel.
//  Write path: any cycle with pool_valid=1 and pool_rst_n=1 (FEED or DRAIN):
//   - registered next cycle: wr_en=1, wr_data=pool_out, wr_addr=ch*NPOOL+out_cnt;
//   - out_cnt++ (saturates at NPOOL; extra valids ignored, no write).
//   pool_valid while pool_rst_n=0 is ignored.
//  DRAIN exit: NPOOL is reached counting the valid, the final write issues in the cycle after the valid;
//   it completes before or in the same cycle NEXT is entered. No write is ever dropped at a channel boundary.
//  Simultaneous: the last read (FEED->DRAIN) and a pool_valid in the same cycle -> both honoured.
//  Counters: pix_cnt clog2(NPIX) bits, out_cnt clog2(NPOOL+1) bits, ch clog2(CHANNELS) bits;
//   address products computed at full RD_AW/WR_AW width, no wrap.
//  rst_n asserted mid-frame: immediate return to reset values. Partial RAM contents are undefined; no done is issued.
// TESTING (bench: WIDTH=HEIGHT=4, CHANNELS=2, real max_pooling instance, RAM models)
//  1. Both maps all-ones, start -> 8 writes, addr 0..7, data 1; done once; err=0; busy high throughout.
//  2. ch0 bits {0,5,10,15}=1 only, ch1 all-zero -> wr_data ch0 {1,0,0,1} at addr 0..3; ch1 addr 4..7 = 0.
//  3. Check read sequence -> rd_addr 0..15 contiguous, then 16..31; pool_rst_n low exactly 2 cycles before each channel.
//  4. Pooling valid forced stuck low -> DRAIN exits after 64 cycles per channel; err=1; done still pulses.
//     Next start clears err.
//  5. start pulsed during FEED and during DONE -> ignored; exactly one done; wr_addr sequence unchanged.
//  6. rst_n low at pixel 9 of ch1 -> all outputs at reset values same cycle. A new start yields the full 8-write sequence.

Source files
------------

// File: rtl/maxpool_frame_ctrl.sv
// maxpool_frame_ctrl: streams CHANNELS binary feature maps from the conv bit-RAM through max_pooling
// and packs each pooled bit into the pool output bit-RAM, one channel at a time.
module maxpool_frame_ctrl #(
  parameter int WIDTH     = 26,
  parameter int HEIGHT    = 26,
  parameter int CHANNELS  = 4,
  parameter int RD_AW     = 12,
  parameter int WR_AW     = 10,
  parameter int DRAIN_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_en,
  output logic [RD_AW-1:0] rd_addr,
  input  logic             rd_data,
  output logic             pool_rst_n,
  output logic             pool_pixel,
  input  logic             pool_out,
  input  logic             pool_valid,
  output logic             wr_en,
  output logic [WR_AW-1:0] wr_addr,
  output logic             wr_data
);
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int NPOOL = (WIDTH / 2) * (HEIGHT / 2);
  localparam int PW    = $clog2(NPIX);
  localparam int OW    = $clog2(NPOOL + 1);
  localparam int CW    = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int DW    = DRAIN_MAX > 1 ? $clog2(DRAIN_MAX) : 1;
  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, NEXT, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [PW-1:0]    pix_q, pix_d;
  logic [OW-1:0]    out_q, out_d;
  logic [DW-1:0]    drn_q, drn_d;
  logic             clr_q, clr_d;
  logic             err_q, err_d;
  logic             rd_vld_q, rd_vld_d;
  logic             pool_pixel_q, pool_pixel_d;
  logic             wr_en_q, wr_en_d;
  logic [WR_AW-1:0] wr_addr_q, wr_addr_d;
  logic             wr_data_q, wr_data_d;
  logic             accept;
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    pix_d        = pix_q;
    out_d        = out_q;
    drn_d        = drn_q;
    clr_d        = clr_q;
    err_d        = err_q;
    rd_vld_d     = rd_en;
    pool_pixel_d = rd_vld_q ? rd_data : 1'b0;
    accept       = pool_valid && (state_q == FEED || state_q == DRAIN) && out_q != OW'(NPOOL);
    wr_en_d      = accept;
    wr_addr_d    = accept ? WR_AW'(ch_q) * WR_AW'(NPOOL) + WR_AW'(out_q) : wr_addr_q;
    wr_data_d    = accept ? pool_out : wr_data_q;
    out_d        = accept ? out_q + 1'b1 : out_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLR;
        ch_d    = '0;
        err_d   = 1'b0;
        clr_d   = 1'b0;
      end
      CLR: begin
        pix_d   = '0;
        out_d   = '0;
        clr_d   = ~clr_q;
        state_d = clr_q ? FEED : CLR;
      end
      FEED: begin
        pix_d = pix_q + 1'b1;
        drn_d = '0;
        state_d = pix_q == PW'(NPIX - 1) ? DRAIN : FEED;
      end
      DRAIN: begin
        drn_d = drn_q + 1'b1;
        if (out_q == OW'(NPOOL)) state_d = NEXT;
        else if (drn_q == DW'(DRAIN_MAX - 1)) begin
          err_d   = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        state_d = ch_q == CW'(CHANNELS - 1) ? DONE : CLR;
        ch_d    = ch_q == CW'(CHANNELS - 1) ? ch_q : ch_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      pix_q        <= '0;
      out_q        <= '0;
      drn_q        <= '0;
      clr_q        <= 1'b0;
      err_q        <= 1'b0;
      rd_vld_q     <= 1'b0;
      pool_pixel_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      pix_q        <= pix_d;
      out_q        <= out_d;
      drn_q        <= drn_d;
      clr_q        <= clr_d;
      err_q        <= err_d;
      rd_vld_q     <= rd_vld_d;
      pool_pixel_q <= pool_pixel_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end
  // NEXT keeps the pooling block out of reset so the inter-channel reset pulse is exactly the CLR length
  assign pool_rst_n = state_q == FEED || state_q == DRAIN || state_q == NEXT;
  assign busy       = state_q != IDLE;
  assign done       = state_q == DONE;
  assign err        = err_q;
  assign rd_en      = state_q == FEED;
  assign rd_addr    = RD_AW'(ch_q) * RD_AW'(NPIX) + RD_AW'(pix_q);
  assign pool_pixel = pool_pixel_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
endmodule

// File: tb/tb_maxpool_frame_ctrl.sv
// tb_maxpool_frame_ctrl: random binary maps through the controller with RAM and pooling-block models;
// a scoreboard of expected pooled writes is built from the input maps and checked by a monitor.
`timescale 1ns/1ps
module tb_maxpool_frame_ctrl;
  localparam int W = 4, H = 4, C = 2, NPIX = W * H, NPOOL = (W / 2) * (H / 2), DMAX = 64;
  logic clk = 0, rst_n = 1, start = 0;
  logic busy, done, err, rd_en, rd_data = 0, pool_rst_n, pool_pixel, pool_out = 0, pool_valid = 0;
  logic wr_en, wr_data;
  logic [11:0] rd_addr;
  logic [9:0]  wr_addr;
  maxpool_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .CHANNELS(C), .RD_AW(12), .WR_AW(10), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .pool_rst_n(pool_rst_n),
    .pool_pixel(pool_pixel), .pool_out(pool_out), .pool_valid(pool_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
  always #5 clk = ~clk;
  typedef struct packed {logic [9:0] a; logic d;} exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0;
  bit in_ram [0:4095];
  bit out_ram [0:1023];
  bit stuck = 0, sb_off = 0, measure_gap = 0, gap_armed = 0;
  int rd_exp = 0, gap = 0, low_run = 0, feeds = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  always @(posedge clk) begin
    if (rd_en) rd_data <= in_ram[rd_addr];
    if (wr_en) out_ram[wr_addr] = wr_data;
  end
  // pooling block model: counts pixels from reset release, pixel 0 arriving on the third cycle
  int pcyc = 0;
  bit win [0:NPOOL-1];
  always @(posedge clk) begin : pool_model
    int idx, r, c, w;
    if (!pool_rst_n) begin
      pcyc = 0;
      for (int i = 0; i < NPOOL; i++) win[i] = 0;
      pool_valid <= 0;
    end else begin
      pool_valid <= 0;
      if (pcyc >= 2 && pcyc < NPIX + 2) begin
        idx = pcyc - 2; r = idx / W; c = idx % W; w = (r / 2) * (W / 2) + c / 2;
        win[w] = win[w] | pool_pixel;
        if (r % 2 == 1 && c % 2 == 1) begin
          if (!stuck) begin pool_valid <= 1; pool_out <= win[w]; end
          win[w] = 0;
        end
      end
      pcyc++;
    end
  end
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (wr_en && !sb_off) begin
        if (sbq.size() == 0) chk("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
        else begin
          e = sbq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.a));
          chk("wr_data", 32'(wr_data), 32'(e.d));
        end
      end
      if (rd_en) begin
        chk("rd_addr_seq", 32'(rd_addr), 32'(rd_exp));
        rd_exp++;
        if (measure_gap && gap_armed && gap > 0) chk("drain_timeout_gap", gap, DMAX + 3);
        gap = 0; gap_armed = 1;
      end else gap++;
      if (!pool_rst_n) low_run++;
      else begin
        if (low_run > 0 && feeds > 0) chk("pool_rst_low_len", low_run, 2);
        if (low_run > 0) feeds++;
        low_run = 0;
      end
    end
  end
  task automatic push_expected();
    bit v;
    for (int ch = 0; ch < C; ch++)
      for (int wr = 0; wr < H / 2; wr++)
        for (int wc = 0; wc < W / 2; wc++) begin
          v = 0;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) v |= in_ram[ch * NPIX + (2 * wr + dr) * W + 2 * wc + dc];
          sbq.push_back('{a: 10'(ch * NPOOL + wr * (W / 2) + wc), d: v});
        end
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, "_ctl"}, 32'({busy, done, err, rd_en, wr_en, pool_rst_n, wr_data, pool_pixel}), 0);
    chk({nm, "_addr"}, 32'({rd_addr, wr_addr}), 0);
  endtask
  task automatic run_frame(input bit stuck_v, input bit inj, input bit exp_err, input int rst_pix);
    int ndone = 0, cyc = 0, post = 0;
    bit busy_ok = 1, inj_feed = 0, fin = 0;
    stuck = stuck_v; measure_gap = stuck_v; sb_off = rst_pix >= 0;
    feeds = 0; rd_exp = 0; gap_armed = 0; gap = 0;
    if (!stuck_v && rst_pix < 0) push_expected();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    chk("busy_after_start", 32'(busy), 1);
    chk("err_cleared_by_start", 32'(err), 0);
    while (!fin && cyc < 2000) begin
      @(negedge clk); cyc++; start = 0;
      if (rst_pix >= 0 && rd_en && int'(rd_addr) == NPIX + rst_pix) begin
        #2 rst_n = 0;
        #1 chk_reset("midframe_reset");
        @(negedge clk); rst_n = 1;
        fin = 1;
      end else begin
        if (done) begin
          ndone++;
          if (!busy) busy_ok = 0;
          if (inj) start = 1;
        end else if (ndone == 0 && !busy) busy_ok = 0;
        if (inj && rd_en && !inj_feed && rd_addr == 12'd5) begin start = 1; inj_feed = 1; end
        if (ndone > 0) post++;
        if (post == 4) fin = 1;
      end
    end
    start = 0;
    chk("frame_finished_in_bound", 32'(fin), 1);
    if (rst_pix < 0) begin
      chk("done_count", ndone, 1);
      chk("busy_through_frame", 32'(busy_ok), 1);
      chk("err_after_frame", 32'(err), 32'(exp_err));
      chk("scoreboard_empty", sbq.size(), 0);
      chk("idle_after_frame", 32'(busy), 0);
    end else begin
      chk("no_done_on_reset", ndone, 0);
      sbq.delete();
    end
    sb_off = 0;
  endtask
  task automatic fill_random();
    for (int i = 0; i < C * NPIX; i++) in_ram[i] = 1'($urandom_range(0, 3) == 0);
  endtask
  initial begin
    logic [7:0] exp2;
    #1 rst_n = 0;
    #2 chk_reset("power_on");
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < C * NPIX; i++) in_ram[i] = 1;
    for (int i = 0; i < C * NPOOL; i++) out_ram[i] = 0;
    run_frame(0, 0, 0, -1);
    for (int i = 0; i < C * NPOOL; i++) chk("all_ones_ram", 32'(out_ram[i]), 1);
    for (int i = 0; i < C * NPIX; i++) in_ram[i] = 0;
    in_ram[0] = 1; in_ram[5] = 1; in_ram[10] = 1; in_ram[15] = 1;
    for (int i = 0; i < C * NPOOL; i++) out_ram[i] = 1;
    run_frame(0, 0, 0, -1);
    exp2 = 8'b0000_1001;
    for (int i = 0; i < C * NPOOL; i++) chk("diag_ram", 32'(out_ram[i]), 32'(exp2[i]));
    fill_random();
    run_frame(1, 0, 1, -1);
    fill_random();
    run_frame(0, 0, 0, -1);
    fill_random();
    run_frame(0, 1, 0, -1);
    fill_random();
    run_frame(0, 0, 0, 9);
    for (int i = 0; i < C * NPIX; i++) in_ram[i] = 1;
    for (int i = 0; i < C * NPOOL; i++) out_ram[i] = 0;
    run_frame(0, 0, 0, -1);
    for (int i = 0; i < C * NPOOL; i++) chk("after_reset_ram", 32'(out_ram[i]), 1);
    repeat (5) begin
      fill_random();
      run_frame(0, 0, 0, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
